// File: rtl/pwm_multi_pkg.sv
// pwm_multi register map and CTRL bit positions, shared by the peripheral
// and its timebase. Optional feature macro: PWM_CENTER_EN.
package pwm_multi_pkg;

  // Register word offsets
  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_PRESCALE = 1;
  localparam int unsigned REG_PERIOD   = 2;
  localparam int unsigned REG_STATUS   = 3;
  localparam int unsigned REG_DUTY0    = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_MODE    = 2;
  localparam int unsigned CTRL_POL_LSB = 16;

  // STATUS layout: counter snapshot in the upper half, wrap flag in bit 0
  localparam int unsigned STATUS_CNT_LSB = 16;
  localparam int unsigned STATUS_CNT_W   = 16;

endpackage : pwm_multi_pkg

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter for pwm_multi. Produces the counter
// value and the single-cycle wrap event at which active period/duty reload.
// With PWM_CENTER_EN defined, a direction flop adds up/down (centre-aligned)
// counting selected by mode_i; otherwise the counter is edge-aligned only.
module pwm_timebase
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
`ifdef PWM_CENTER_EN
  input  logic             mode_i,
`endif
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_act_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_c_o
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  // Prescaler: >= also recovers if PRESCALE is lowered below the running count
  always_comb begin
    tick_c    = en_i && (pre_cnt_q >= prescale_i);
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    if (!en_i || tick_c) begin
      pre_cnt_d = '0;
    end
  end

`ifdef PWM_CENTER_EN
  logic dir_up_q, dir_up_d;

  // Counter: edge-aligned ramp or up/down triangle; disabled parks at 0 counting down
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    wrap_c_o = 1'b0;
    if (!en_i) begin
      cnt_d    = '0;
      dir_up_d = 1'b0;
    end else if (tick_c) begin
      if (mode_i) begin
        if (!dir_up_q) begin
          if (cnt_q == '0) begin
            // Bottom of the triangle: reload point, then climb again
            wrap_c_o = 1'b1;
            dir_up_d = (period_act_i != '0);
            cnt_d    = (period_act_i != '0) ? CNT_W'(1) : '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (cnt_q >= period_act_i) begin
          dir_up_d = 1'b0;
          cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        dir_up_d = 1'b0;
        if (cnt_q == period_act_i) begin
          wrap_c_o = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Direction register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_up_q <= 1'b0;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`else
  // Counter: edge-aligned ramp 0..period_act, wrapping to 0
  always_comb begin
    cnt_d    = cnt_q;
    wrap_c_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_c) begin
      if (cnt_q == period_act_i) begin
        wrap_c_o = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end
`endif

  // Prescaler and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pwm_timebase

// File: rtl/pwm_multi.sv
// Multi-channel memory-mapped PWM: shared timebase, per-channel duty and
// polarity, double-buffered period/duty reloaded at wrap, wrap interrupt.
// Optional feature macro: PWM_CENTER_EN (CTRL.mode, centre-aligned counting).
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [N_CH-1:0]   pwm_o,
  output logic              irq
);

  logic              wr_c, rd_c;
  logic              wr_ctrl_c, wr_pre_c, wr_per_c, wr_stat_c;
  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic [N_CH-1:0]   pol_q, pol_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  period_act_q;
  logic              wrap_q, wrap_d;
  logic              irq_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_CH-1:0]   pwm_q, pwm_d;
  logic [CNT_W-1:0]  cnt_c;
  logic              wrap_ev_c;
  logic [N_CH*CNT_W-1:0] duty_sh_flat_c;
  logic              unused_wdata_c;
`ifdef PWM_CENTER_EN
  logic              mode_q, mode_d;
`endif

  // Bus strobes and register decode
  assign wr_c      = sel & we;
  assign rd_c      = sel & ~we;
  assign wr_ctrl_c = wr_c && (addr == ADDR_W'(REG_CTRL));
  assign wr_pre_c  = wr_c && (addr == ADDR_W'(REG_PRESCALE));
  assign wr_per_c  = wr_c && (addr == ADDR_W'(REG_PERIOD));
  assign wr_stat_c = wr_c && (addr == ADDR_W'(REG_STATUS));
  assign unused_wdata_c = ^wdata;

  // Control/shadow next state and STATUS.wrap (a wrap beats a same-cycle clear)
  always_comb begin
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    pol_d       = pol_q;
    prescale_d  = prescale_q;
    period_sh_d = period_sh_q;
`ifdef PWM_CENTER_EN
    mode_d      = mode_q;
`endif
    if (wr_ctrl_c) begin
      en_d     = wdata[CTRL_EN];
      irq_en_d = wdata[CTRL_IRQ_EN];
      pol_d    = wdata[CTRL_POL_LSB +: N_CH];
`ifdef PWM_CENTER_EN
      mode_d   = wdata[CTRL_MODE];
`endif
    end
    if (wr_pre_c) begin
      prescale_d = wdata[PRE_W-1:0];
    end
    if (wr_per_c) begin
      period_sh_d = wdata[CNT_W-1:0];
    end
    wrap_d = wrap_q;
    if (wrap_ev_c) begin
      wrap_d = 1'b1;
    end else if (wr_stat_c && wdata[0]) begin
      wrap_d = 1'b0;
    end
  end

  // Control, shadow, status and irq registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      pol_q       <= '0;
      prescale_q  <= '0;
      period_sh_q <= '0;
      wrap_q      <= 1'b0;
      irq_q       <= 1'b0;
`ifdef PWM_CENTER_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      pol_q       <= pol_d;
      prescale_q  <= prescale_d;
      period_sh_q <= period_sh_d;
      wrap_q      <= wrap_d;
      irq_q       <= wrap_d & irq_en_d;
`ifdef PWM_CENTER_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Active period: follows the shadow while disabled, otherwise reloads at wrap
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period_act_q <= '0;
    end else if (!en_q || wrap_ev_c) begin
      period_act_q <= period_sh_q;
    end
  end

  pwm_timebase #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_timebase (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .en_i        (en_q),
`ifdef PWM_CENTER_EN
    .mode_i      (mode_q),
`endif
    .prescale_i  (prescale_q),
    .period_act_i(period_act_q),
    .cnt_o       (cnt_c),
    .wrap_c_o    (wrap_ev_c)
  );

  // Per-channel duty shadow/active registers and compare
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             duty_wr_c;
    logic [CNT_W-1:0] duty_sh_q, duty_act_q;

    assign duty_wr_c = wr_c && (addr == ADDR_W'(REG_DUTY0 + i));

    // Duty shadow takes bus writes; active copy reloads like the period
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
      end else begin
        if (duty_wr_c) begin
          duty_sh_q <= wdata[CNT_W-1:0];
        end
        if (!en_q || wrap_ev_c) begin
          duty_act_q <= duty_sh_q;
        end
      end
    end

    assign pwm_d[i] = en_q ? ((cnt_c < duty_act_q) ^ pol_q[i]) : pol_q[i];
    assign duty_sh_flat_c[i*CNT_W +: CNT_W] = duty_sh_q;
  end

  // Read mux: captured only on a read strobe, unmapped words return 0
  always_comb begin
    rdata_d = rdata_q;
    if (rd_c) begin
      rdata_d = '0;
      if (addr == ADDR_W'(REG_CTRL)) begin
        rdata_d[CTRL_EN]               = en_q;
        rdata_d[CTRL_IRQ_EN]           = irq_en_q;
        rdata_d[CTRL_POL_LSB +: N_CH]  = pol_q;
`ifdef PWM_CENTER_EN
        rdata_d[CTRL_MODE]             = mode_q;
`endif
      end else if (addr == ADDR_W'(REG_PRESCALE)) begin
        rdata_d = 32'(prescale_q);
      end else if (addr == ADDR_W'(REG_PERIOD)) begin
        rdata_d = 32'(period_sh_q);
      end else if (addr == ADDR_W'(REG_STATUS)) begin
        rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(cnt_c);
        rdata_d[0]                              = wrap_q;
      end else begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (addr == ADDR_W'(REG_DUTY0 + i)) begin
            rdata_d = 32'(duty_sh_flat_c[i*CNT_W +: CNT_W]);
          end
        end
      end
    end
  end

  // Read data and PWM output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata_q <= '0;
      pwm_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      pwm_q   <= pwm_d;
    end
  end

  assign rdata = rdata_q;
  assign pwm_o = pwm_q;
  assign irq   = irq_q;

endmodule : pwm_multi

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (4 channels, 16-bit counter).
// Expected values are queued when stimulus is driven and popped on output.
// Optional feature macro: PWM_CENTER_EN enables the centre-aligned checks.
module tb_pwm_multi;
  import pwm_multi_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  pwm_o;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  pwm_multi #(
    .N_CH  (4),
    .CNT_W (16),
    .PRE_W (16),
    .ADDR_W(5)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .pwm_o(pwm_o),
    .irq  (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int unsigned a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = 5'(a); wdata = d;
    @(posedge CLK); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input int unsigned a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = 5'(a);
    exp_q.push_back(exp);
    @(posedge CLK); #1;
    sel = 1'b0;
    check($sformatf("rd_addr%0d", a), rdata, exp_q.pop_front());
  endtask

  // Expected observation after edge k counted from the enabling write (edge 0)
  function automatic logic [31:0] exp_val(input int scen, input int k);
    int c, cnt, d0, m;
    logic [31:0] v;
    c = k - 1;
    cnt = 0; d0 = 3; v = '0;
    case (scen)
      0: cnt = c % 10;
      1: begin cnt = c % 10; d0 = (c >= 10) ? 7 : 3; end
      2: cnt = (c < 10) ? c : (c - 10) % 5;
      3: return ((k == 8) || (k >= 16)) ? 32'd1 : 32'd0;
      default: begin
        m = c % 8;
        cnt = (m <= 4) ? m : 8 - m;
        return (cnt < 2) ? 32'd1 : 32'd0;
      end
    endcase
    v[0] = (cnt < d0);
    v[1] = 1'b0;
    v[2] = 1'b1;
    v[3] = !(cnt < 3);
    return v;
  endfunction

  function automatic logic [31:0] obs_val(input int scen);
    case (scen)
      0, 1, 2: return 32'(pwm_o);
      3:       return 32'(irq);
      default: return 32'(pwm_o[0]);
    endcase
  endfunction

  // Cycle-by-cycle tracking with up to two bus writes landing on edges wk1/wk2
  task automatic track(input int scen, input int n, input int wk1, input int wk2,
                       input int unsigned wa, input logic [31:0] wd);
    for (int k = 1; k <= n; k++) begin
      if (k == wk1 || k == wk2) begin
        sel = 1'b1; we = 1'b1; addr = 5'(wa); wdata = wd;
      end else begin
        sel = 1'b0; we = 1'b0;
      end
      exp_q.push_back(exp_val(scen, k));
      @(posedge CLK); #1;
      check($sformatf("s%0d_k%0d", scen, k), obs_val(scen), exp_q.pop_front());
    end
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic restart(input logic [31:0] ctrl_run, input logic [31:0] period,
                         input logic [31:0] d0);
    bus_write(REG_CTRL, ctrl_run & ~32'h1);
    bus_write(REG_PERIOD, period);
    bus_write(REG_DUTY0, d0);
    bus_write(REG_CTRL, ctrl_run);
  endtask

  initial begin
    logic [31:0] exp_mode;
    RESET = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pwm", 32'(pwm_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    RESET = 1'b0;
    @(posedge CLK); #1;

`ifdef PWM_CENTER_EN
    exp_mode = 32'h4;
`else
    exp_mode = 32'h0;
`endif
    bus_write(REG_CTRL, 32'h4);
    bus_read(REG_CTRL, exp_mode);
    bus_write(REG_CTRL, 32'h0);
    bus_write(8, 32'hDEAD_BEEF);
    bus_read(8, 32'h0);

    bus_write(REG_DUTY0 + 1, 32'd0);
    bus_write(REG_DUTY0 + 2, 32'd20);
    bus_write(REG_DUTY0 + 3, 32'd3);
    bus_read(REG_DUTY0 + 2, 32'd20);

    // Basic duty, extremes and inverted polarity on channel 3
    restart(32'h0008_0001, 32'd9, 32'd3);
    track(0, 40, -1, -1, 0, 32'h0);
    bus_read(REG_STATUS, 32'h0000_0001);
    bus_write(REG_STATUS, 32'h1);
    bus_read(REG_STATUS, 32'h0002_0000);

    // Mid-period duty write applies only after the wrap
    restart(32'h0008_0001, 32'd9, 32'd3);
    track(1, 30, 6, -1, REG_DUTY0, 32'd7);
    bus_read(REG_DUTY0, 32'd7);

    // Mid-period period write applies only after the wrap
    restart(32'h0008_0001, 32'd9, 32'd3);
    track(2, 30, 3, -1, REG_PERIOD, 32'd4);
    bus_read(REG_PERIOD, 32'd4);

    // Prescaler, irq, W1C alone and W1C colliding with a wrap
    bus_write(REG_CTRL, 32'h0);
    bus_write(REG_STATUS, 32'h1);
    bus_write(REG_PRESCALE, 32'd3);
    bus_write(REG_PERIOD, 32'd1);
    bus_write(REG_CTRL, 32'h3);
    track(3, 17, 9, 16, REG_STATUS, 32'h1);
    bus_read(REG_STATUS, 32'h0000_0001);

    // Asynchronous reset mid-operation
    #2;
    RESET = 1'b1;
    #1;
    check("arst_pwm", 32'(pwm_o), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_rdata", rdata, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int unsigned a = 0; a < 8; a++) begin
      bus_read(a, 32'h0);
    end

`ifdef PWM_CENTER_EN
    // Centre-aligned: triangle 0..4..0, high while cnt < 2
    bus_write(REG_PERIOD, 32'd4);
    bus_write(REG_DUTY0, 32'd2);
    bus_write(REG_CTRL, 32'h5);
    track(4, 20, -1, -1, 0, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_multi
